// File: rtl/aib_dly_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// aib_dly_ctrl_pkg
// Shared types and default constants for the AIB delay-code controller.
//   dly_state_e : controller FSM state (IDLE / ACQUIRE / TRACK)
//   step_dir_e  : direction of the last code step (NONE = no step since load)
//   DEF_*       : default parameter values for aib_dly_code_ctrl
// ---------------------------------------------------------------------------
package aib_dly_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } dly_state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } step_dir_e;

    localparam int DEF_NUM_CELLS = 16;
    localparam int DEF_FILT_LEN  = 4;
    localparam int DEF_LOCK_CNT  = 6;

    // Counter widths sized for the largest legal FILT_LEN / LOCK_CNT (15).
    localparam int VOTE_W = 5;   // signed, holds -15..+15
    localparam int REV_W  = 4;   // unsigned, holds 0..15

endpackage

// File: rtl/aib_dly_bin2therm.sv
// ---------------------------------------------------------------------------
// aib_dly_bin2therm
// Registered binary-to-thermometer encoder for the NAND delay-chain enables.
// Bit i of therm is set when the binary code is greater than i.
// The input is the controller's next-state code, so therm lands on the same
// edge as the registered binary code.
//   clk   : clock
//   rst   : asynchronous active-high reset (therm clears to 0)
//   bin   : binary code to encode (next-state value)
//   therm : registered thermometer code, one bit per delay cell
// ---------------------------------------------------------------------------
module aib_dly_bin2therm #(
    parameter int NUM_CELLS = 16,
    parameter int CODE_W    = $clog2(NUM_CELLS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CODE_W-1:0]    bin,
    output logic [NUM_CELLS-1:0] therm
);

    logic [NUM_CELLS-1:0] therm_nxt;

    always_comb begin
        therm_nxt = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            therm_nxt[i] = (32'(bin) > 32'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            therm <= '0;
        end else begin
            therm <= therm_nxt;
        end
    end

endmodule

// File: rtl/aib_dly_code_ctrl.sv
// ---------------------------------------------------------------------------
// aib_dly_code_ctrl
// Filters phase-detector early/late votes and steps a saturating delay code
// for the AIB NAND2 delay chain. Reports lock and code-range flags.
//
// Optional feature macro: AIB_DLY_CTRL_OVRD_EN adds ovrd_en / ovrd_code,
// which force the code directly and park the FSM in IDLE.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   en              : run enable; its 0->1 edge loads clamped code_init
//   code_init       : start code (clamped to NUM_CELLS)
//   pd_valid        : qualifies pd_early / pd_late this cycle
//   pd_early        : up vote (more delay needed)
//   pd_late         : down vote (less delay needed)
//   ovrd_en/ovrd_code (macro only) : direct code override
//   dly_bin         : registered binary delay code
//   dly_therm       : registered thermometer code (bit i = dly_bin > i)
//   locked          : high while in TRACK
//   at_min / at_max : dly_bin == 0 / dly_bin == NUM_CELLS
//   dbg_state       : current FSM state, for observation only
//
// Vote qualification: pd_valid is a one-sided strobe with no back-pressure.
// A vote is taken on any edge where pd_valid=1 and exactly one of
// pd_early/pd_late is 1; both or neither means no vote for that cycle.
// ---------------------------------------------------------------------------
module aib_dly_code_ctrl
    import aib_dly_ctrl_pkg::*;
#(
    parameter int NUM_CELLS = DEF_NUM_CELLS,
    parameter int FILT_LEN  = DEF_FILT_LEN,
    parameter int LOCK_CNT  = DEF_LOCK_CNT,
    parameter int CODE_W    = $clog2(NUM_CELLS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [CODE_W-1:0]    code_init,
    input  logic                 pd_valid,
    input  logic                 pd_early,
    input  logic                 pd_late,
`ifdef AIB_DLY_CTRL_OVRD_EN
    input  logic                 ovrd_en,
    input  logic [CODE_W-1:0]    ovrd_code,
`endif
    output logic [CODE_W-1:0]    dly_bin,
    output logic [NUM_CELLS-1:0] dly_therm,
    output logic                 locked,
    output logic                 at_min,
    output logic                 at_max,
    output dly_state_e           dbg_state
);

    localparam logic [CODE_W-1:0]        MAX_CODE     = CODE_W'(NUM_CELLS);
    localparam logic [CODE_W-1:0]        ONE_CODE     = CODE_W'(1);
    localparam logic signed [VOTE_W-1:0] VOTE_ONE     = VOTE_W'(1);
    // A vote arriving with the counter one short of the threshold is the step.
    localparam logic signed [VOTE_W-1:0] VOTE_UP_LAST = VOTE_W'(FILT_LEN - 1);
    localparam logic signed [VOTE_W-1:0] VOTE_DN_LAST = VOTE_W'(1 - FILT_LEN);
    localparam logic [REV_W-1:0]         LOCK_MAX     = REV_W'(LOCK_CNT);
    localparam logic [REV_W-1:0]         REV_ONE      = REV_W'(1);

    function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] c);
        return (c > MAX_CODE) ? MAX_CODE : c;
    endfunction

    dly_state_e                 state, state_nxt;
    step_dir_e                  last_dir, last_dir_nxt, step_dir;
    logic signed [VOTE_W-1:0]   vote_cnt, vote_nxt;
    logic [REV_W-1:0]           rev_cnt, rev_nxt;
    logic [CODE_W-1:0]          code_nxt;
    logic                       en_q;
    logic                       en_rise;
    logic                       vote_up, vote_dn;

    assign en_rise   = en & ~en_q;
    assign vote_up   = pd_valid &  pd_early & ~pd_late;
    assign vote_dn   = pd_valid & ~pd_early &  pd_late;
    assign dbg_state = state;

    always_comb begin
        state_nxt    = state;
        code_nxt     = dly_bin;
        vote_nxt     = vote_cnt;
        rev_nxt      = rev_cnt;
        last_dir_nxt = last_dir;
        step_dir     = DIR_NONE;

        if (!en) begin
            // Dropping en beats any step on the same edge; code holds.
            state_nxt = ST_IDLE;
        end else if (state == ST_IDLE) begin
            if (en_rise) begin
                code_nxt     = clamp_code(code_init);
                vote_nxt     = '0;
                rev_nxt      = '0;
                last_dir_nxt = DIR_NONE;
                state_nxt    = ST_ACQUIRE;
            end
        end else begin
            if (vote_up) begin
                if (vote_cnt == VOTE_UP_LAST) step_dir = DIR_UP;
                else                          vote_nxt = vote_cnt + VOTE_ONE;
            end else if (vote_dn) begin
                if (vote_cnt == VOTE_DN_LAST) step_dir = DIR_DOWN;
                else                          vote_nxt = vote_cnt - VOTE_ONE;
            end

            if (step_dir != DIR_NONE) begin
                vote_nxt     = '0;
                last_dir_nxt = step_dir;
                // Saturated steps leave the code alone but still count below.
                if (step_dir == DIR_UP && dly_bin != MAX_CODE)
                    code_nxt = dly_bin + ONE_CODE;
                else if (step_dir == DIR_DOWN && dly_bin != '0)
                    code_nxt = dly_bin - ONE_CODE;

                // The first step after a load has nothing to compare against.
                if (last_dir != DIR_NONE) begin
                    if (step_dir != last_dir) begin
                        if (rev_cnt != LOCK_MAX) rev_nxt = rev_cnt + REV_ONE;
                        if (rev_nxt == LOCK_MAX) state_nxt = ST_TRACK;
                    end else begin
                        // Two same-direction steps in a row: drifting, not dithering.
                        rev_nxt   = '0;
                        state_nxt = ST_ACQUIRE;
                    end
                end
            end
        end

`ifdef AIB_DLY_CTRL_OVRD_EN
        if (ovrd_en) begin
            code_nxt     = clamp_code(ovrd_code);
            state_nxt    = ST_IDLE;
            vote_nxt     = '0;
            rev_nxt      = '0;
            last_dir_nxt = DIR_NONE;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            en_q     <= 1'b0;
            dly_bin  <= '0;
            vote_cnt <= '0;
            rev_cnt  <= '0;
            last_dir <= DIR_NONE;
            locked   <= 1'b0;
            at_min   <= 1'b1;
            at_max   <= 1'b0;
        end else begin
            state    <= state_nxt;
            en_q     <= en;
            dly_bin  <= code_nxt;
            vote_cnt <= vote_nxt;
            rev_cnt  <= rev_nxt;
            last_dir <= last_dir_nxt;
            locked   <= (state_nxt == ST_TRACK);
            at_min   <= (code_nxt == '0);
            at_max   <= (code_nxt == MAX_CODE);
        end
    end

    aib_dly_bin2therm #(
        .NUM_CELLS (NUM_CELLS),
        .CODE_W    (CODE_W)
    ) u_bin2therm (
        .clk   (clk),
        .rst   (rst),
        .bin   (code_nxt),
        .therm (dly_therm)
    );

endmodule

// File: doc/aib_dly_code_ctrl.md
# aib_dly_code_ctrl

Digital controller that drives the enable inputs of the NAND2-based delay chain in the AIB DLL/DCC path. It filters early/late decisions from the phase detector and steps a saturating delay code up or down. The code is presented both as binary and as a thermometer code (one bit per NAND delay cell). The block also reports lock status and code-range flags to the calibration sequencer.

## Interface
Parameters:
- NUM_CELLS, 16: number of NAND delay cells. CODE_W = $clog2(NUM_CELLS+1).
- FILT_LEN, 4: net votes in one direction required to take one code step; range 1..15.
- LOCK_CNT, 6: consecutive step reversals required to declare lock; range 1..15.

Ports:
- clk input 1: controller clock.
- rst input 1: reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- en input 1: run enable. The 0→1 edge loads code_init.
- code_init input CODE_W: start code. Values above NUM_CELLS are clamped to NUM_CELLS.
- pd_valid input 1: qualifies pd_early/pd_late this cycle.
- pd_early input 1: output edge early, meaning more delay is needed (up vote).
- pd_late input 1: output edge late, meaning less delay is needed (down vote).
- dly_bin output CODE_W: current delay code.
- dly_therm output NUM_CELLS: thermometer code. Bit i = (dly_bin > i).
- locked output 1: high while the FSM is in TRACK.
- at_min output 1: dly_bin == 0.
- at_max output 1: dly_bin == NUM_CELLS.

## Operation
- **FSM states:** IDLE, ACQUIRE, TRACK.
- **IDLE:**
  - All votes are ignored.
  - On the en 0→1 edge, load the clamped code_init into dly_bin, clear the vote and reversal counters, and go to ACQUIRE.
- **en low:** in any state, go to IDLE next edge. dly_bin holds its value.
- **Vote counter:** signed, range −FILT_LEN..+FILT_LEN.
  - A vote counts only when pd_valid=1 and exactly one of pd_early/pd_late is 1. Both or neither counts as no vote.
  - A vote that brings the counter to +FILT_LEN causes an up step; −FILT_LEN causes a down step. The counter clears to 0 on any step.
- **Saturation:**
  - An up step at NUM_CELLS or a down step at 0 leaves the code unchanged.
  - Such a step still clears the vote counter and still counts for reversal tracking.
- **Reversal tracking:**
  - last_dir is stored from the previous step and is invalid after load.
  - A step opposite last_dir increments the reversal counter, saturating at LOCK_CNT.
  - A step in the same direction clears it.
- **ACQUIRE → TRACK:** on the step that makes the reversal counter reach LOCK_CNT.
- **TRACK:**
  - Stepping continues.
  - Two consecutive same-direction steps clear the reversal counter and return the FSM to ACQUIRE.

## Timing
- **Reset values:** dly_bin=0, dly_therm=0, locked=0, at_min=1, at_max=0, state IDLE, all counters 0, last_dir invalid.
- **Registered outputs:** dly_bin, dly_therm, locked, at_min and at_max are all registered and update on the same edge. There is no combinational path from the inputs.
- **Step latency:** the qualifying vote sampled at edge N produces the new dly_bin after edge N (visible in cycle N+1).
- **Load latency:** en sampled high at edge N (low at N−1) makes dly_bin = code_init after edge N.
- **Lock latency:** locked rises after the edge of the lock-qualifying step and falls after the edge of the second same-direction step.
- **Reset mid-operation:** all state returns to reset values immediately, without waiting for clk.
- **Simultaneous events:**
  - en falling wins over a step on the same edge; no step is taken.
  - A load on the en rising edge overrides any vote sampled on that edge.

## Configuration
- **Macro: AIB_DLY_CTRL_OVRD_EN.**
- **Defined:** adds ports ovrd_en (input, 1) and ovrd_code (input, CODE_W).
  - While ovrd_en=1: dly_bin = clamped ovrd_code on the next edge, the FSM is forced to IDLE, locked=0, and counters clear.
  - When ovrd_en falls, the block waits for the next en 0→1 edge.
- **Undefined:** the ports are absent and behaviour is exactly as above.

## Structure
- **Package aib_dly_ctrl_pkg:**
  - state enum (IDLE/ACQUIRE/TRACK)
  - step-direction enum (NONE/UP/DOWN)
  - default parameter constants
- **Sub-module aib_dly_bin2therm:** registered binary-to-thermometer encoder, parameterised by NUM_CELLS. Instantiated once.

## Test plan
- **Reset:** assert rst mid-run with dly_bin=9 → all outputs return to reset values immediately (dly_bin=0, therm=0, at_min=1).
- **Load:** code_init=20 (above NUM_CELLS=16), en 0→1 → dly_bin=16, dly_therm=16'hFFFF, at_max=1 one edge later.
- **Filter:**
  - Start from code 8 with FILT_LEN=4.
  - Drive 3 early votes, then 1 cycle with both early and late, then 1 early vote → dly_bin=9 after the 4th early vote edge.
  - 3 early votes then 1 late vote gives no step.
- **Saturation:** code 0, 4 late votes → dly_bin stays 0, vote counter cleared, at_min=1.
- **Lock and loss:**
  - Alternate up/down steps from code 8 → locked=1 after the 6th reversal.
  - Then two consecutive up steps → locked=0 after the second step.
- **Override (AIB_DLY_CTRL_OVRD_EN):** in TRACK, ovrd_en=1 with ovrd_code=5 → dly_bin=5 and locked=0 next edge, and votes are ignored until en is re-armed.
